i2s_audio_tx: RTL
=================

Name: i2s_audio_tx

Overview:
Serialises the guest core's parallel stereo DAC samples into a Philips-format I2S stream for the board's external audio DAC. It sits downstream of the guest top, next to the sigma-delta AUDIO_L/AUDIO_R path, and drives I2S_BCK/I2S_LRCK/I2S_DATA when I2S audio is built. The block is fully synchronous to the 50 MHz system clock. It generates BCK by division, so no extra PLL output is needed.

Parameters:
CLK_DIV_HALF, 8, clk cycles per BCK half-period; legal range >=2. Default gives BCK 3.125 MHz.
SAMPLE_WIDTH, 16, width of left_in/right_in; legal range 1..32.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  asynchronous active-low reset
left_in  in  SAMPLE_WIDTH  left sample, two's complement
right_in  in  SAMPLE_WIDTH  right sample, two's complement
mute  in  1  force silence from the next frame
sample_strobe  out  1  one-clk pulse when inputs are latched
i2s_bck  out  1  bit clock
i2s_lrck  out  1  word select; 0 = left, 1 = right
i2s_data  out  1  serial data, MSB first

Behaviour:
- Reset (async assert, sync use after deassert): div_cnt=0, bit_cnt=0, i2s_bck=0, i2s_lrck=0, i2s_data=0, sample_strobe=0, latched L/R=0.
- Divider: div_cnt counts 0..CLK_DIV_HALF-1 and then wraps. At wrap, i2s_bck toggles. A BCK period is 2*CLK_DIV_HALF clk.
- Frame: 64 BCK periods, i.e. two 32-bit slots. With defaults, a frame is 1024 clk and Fs = 48828 Hz.
- All of bit_cnt, i2s_lrck and i2s_data update only on the clk cycle where i2s_bck goes 1->0 (the falling edge). They are registered, so their new values appear in the same cycle as bck low. The DAC samples on the rising edge.
- bit_cnt is 6 bits and advances 63->0 with natural wrap.
- i2s_lrck = bit_cnt[5] as updated; it goes low at bit_cnt 0 and high at bit_cnt 32.
- Data, I2S one-bit delay:
  - bit_cnt = k with 1<=k<=SAMPLE_WIDTH: i2s_data = L[SAMPLE_WIDTH-k].
  - bit_cnt = 32+k: i2s_data = R[SAMPLE_WIDTH-k].
  - All other slots output 0: bit 0, bit 32, and padding.
  - If SAMPLE_WIDTH=32, bit 0 of the frame carries R[0] of the previous frame, and bit 32 carries L[0].
- Latch: on the falling-edge cycle where bit_cnt wraps 63->0:
  - L <= left_in and R <= right_in, or 0 if mute=1 in that cycle.
  - sample_strobe = 1 for exactly that clk cycle, otherwise 0.
- Latency: input to MSB on i2s_data is one BCK period after the latch (2*CLK_DIV_HALF clk).
- Frame integrity: input or mute changes between latches have no effect on the frame in flight.
- First frame after reset outputs all zeros. The first latch occurs 64 BCK periods after reset.
- Reset mid-frame: all outputs return to reset values immediately. No partial-frame completion.
- Width handling: samples are never truncated or sign-extended into padding; padding is always 0.

Optional Feature:
I2S_UNSIGNED_IN_EN:
- Defined: left_in/right_in are offset-binary. The MSB is inverted at latch to convert to two's complement, and mute forces the converted value to 0 (signed silence).
- Undefined: inputs pass through unchanged.

Test Plan:
- Reset held, then released with defaults -> bck period 16 clk; lrck period 1024 clk; first sample_strobe at clk 1024 after release; data 0 throughout frame 0.
- left_in=16'hA5C3, right_in=16'h3C5A held -> frame 1 data at bit_cnt 1..16 = A5C3 MSB-first, 33..48 = 3C5A, all other bits 0; lrck flips at bit_cnt 0 and 32, coincident with bck falling.
- Change left_in to 16'h0001 mid-frame -> frame in flight unchanged; the next frame carries 0001 (bit_cnt 16 = 1, the rest 0).
- mute=1 during the strobe cycle with inputs 16'h7FFF -> that frame is all zeros. Repeat with mute=1 only mid-frame -> no effect.
- Assert reset_n low at bit_cnt 20 -> i2s_bck, i2s_lrck and i2s_data go 0 the same cycle without a clk edge; the restart timing matches the first scenario.
- I2S_UNSIGNED_IN_EN defined, left_in=16'h8000 -> serialised left = 0x0000. Input 16'h0000 -> 0x8000. Mute -> 0x0000.

Source files
------------

// File: rtl/i2s_audio_tx.sv
// Philips I2S serialiser: BCK derived by dividing clk, 64-BCK frames, one-bit data delay.
// Optional build macro I2S_UNSIGNED_IN_EN selects offset-binary sample inputs.
module i2s_audio_tx #(
  parameter int CLK_DIV_HALF = 8,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SAMPLE_WIDTH-1:0] left_in,
  input  logic [SAMPLE_WIDTH-1:0] right_in,
  input  logic                    mute,
  output logic                    sample_strobe,
  output logic                    i2s_bck,
  output logic                    i2s_lrck,
  output logic                    i2s_data
);

  localparam int DIV_W = $clog2(CLK_DIV_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV_HALF - 1);

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic                    bck_q, bck_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic                    lrck_q, lrck_d;
  logic                    data_q, data_d;
  logic                    strobe_q, strobe_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;

  logic                    div_wrap;
  logic                    bck_fall;
  logic [5:0]              next_bit;
  logic [4:0]              sel;
  logic [31:0]             left_al;
  logic [31:0]             right_al;
  logic                    slot_bit;
  logic [SAMPLE_WIDTH-1:0] msb_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
      bit_cnt_q <= '0;
      lrck_q    <= 1'b0;
      data_q    <= 1'b0;
      strobe_q  <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
      bit_cnt_q <= bit_cnt_d;
      lrck_q    <= lrck_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      left_q    <= left_d;
      right_q   <= right_d;
    end
  end

  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    bck_fall  = div_wrap & bck_q;
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    bck_d     = div_wrap ? ~bck_q : bck_q;

    msb_mask = '0;
    msb_mask[SAMPLE_WIDTH-1] = 1'b1;

    // Samples MSB-aligned in a 32-bit slot: slot bit k (1..31) is index 32-k, and
    // the zero-filled low bits give the padding. Index 0 holds the LSB only when
    // SAMPLE_WIDTH is 32, which is what the slot-0 position of the next half needs.
    left_al  = 32'(left_q) << (32 - SAMPLE_WIDTH);
    right_al = 32'(right_q) << (32 - SAMPLE_WIDTH);
    next_bit = bit_cnt_q + 6'd1;
    sel      = 5'd0 - next_bit[4:0];
    if (next_bit[4:0] == 5'd0) begin
      slot_bit = next_bit[5] ? left_al[0] : right_al[0];
    end else begin
      slot_bit = next_bit[5] ? right_al[sel] : left_al[sel];
    end

    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    data_d    = data_q;
    strobe_d  = 1'b0;
    left_d    = left_q;
    right_d   = right_q;

    if (bck_fall) begin
      bit_cnt_d = next_bit;
      lrck_d    = next_bit[5];
      data_d    = slot_bit;
      if (bit_cnt_q == 6'd63) begin
        strobe_d = 1'b1;
`ifdef I2S_UNSIGNED_IN_EN
        left_d   = mute ? '0 : (left_in ^ msb_mask);
        right_d  = mute ? '0 : (right_in ^ msb_mask);
`else
        left_d   = mute ? '0 : left_in;
        right_d  = mute ? '0 : right_in;
`endif
      end
    end
  end

  assign sample_strobe = strobe_q;
  assign i2s_bck       = bck_q;
  assign i2s_lrck      = lrck_q;
  assign i2s_data      = data_q;

endmodule
